// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcodes, FSM states, decode flags and reset defaults for the ALU sequencer
package alu_seq_pkg;
    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_LDA  = 8'h01;
    localparam logic [7:0] OP_LDB  = 8'h02;
    localparam logic [7:0] OP_ADD  = 8'h71;
    localparam logic [7:0] OP_AND  = 8'h72;
    localparam logic [7:0] OP_CLA  = 8'h73;
    localparam logic [7:0] OP_CLB  = 8'h74;
    localparam logic [7:0] OP_CMB  = 8'h75;
    localparam logic [7:0] OP_INCB = 8'h76;
    localparam logic [7:0] OP_DECB = 8'h77;
    localparam logic [7:0] OP_CLC  = 8'h78;
    localparam logic [7:0] OP_CLZ  = 8'h79;
    localparam logic [7:0] OP_ION  = 8'h7A;
    localparam logic [7:0] OP_IOF  = 8'h7B;
    localparam logic [7:0] OP_SC   = 8'h7C;
    localparam logic [7:0] OP_SZ   = 8'h7D;
    localparam logic [7:0] OP_HLT  = 8'hFF;

    localparam logic [11:0] RESET_PC_DEF   = 12'h000;
    localparam logic [11:0] IRQ_VECTOR_DEF = 12'h010;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT, S_WB, S_HALT
    } state_t;

    typedef struct packed {
        logic is_alu;
        logic wr_a;
        logic wr_b;
        logic clr_a;
        logic clr_b;
        logic is_skip;
        logic is_legal;
    } dec_t;
endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: classifies an opcode into the control flags used for dispatch and writeback
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [7:0] i_op,
    output dec_t       o_dec
);
    // pure opcode classification; CLC/CLZ/ION/IOF fall out as ALU ops with no register write
    always_comb begin
        o_dec          = '0;
        o_dec.is_alu   = (i_op >= OP_ADD) && (i_op <= OP_SZ);
        o_dec.wr_a     = (i_op == OP_ADD) || (i_op == OP_AND);
        o_dec.wr_b     = (i_op == OP_CMB) || (i_op == OP_INCB) || (i_op == OP_DECB);
        o_dec.clr_a    = (i_op == OP_CLA);
        o_dec.clr_b    = (i_op == OP_CLB);
        o_dec.is_skip  = (i_op == OP_SC) || (i_op == OP_SZ);
        o_dec.is_legal = o_dec.is_alu || (i_op inside {OP_NOP, OP_LDA, OP_LDB, OP_HLT});
    end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/decode/issue controller that drives the ALU and commits its results
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter logic [11:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [11:0] IRQ_VECTOR = IRQ_VECTOR_DEF
) (
    input  logic        pixel_clock,
    input  logic        reset_n,
    input  logic        start,
    output logic [11:0] imem_addr,
    output logic        imem_en,
    input  logic [15:0] imem_data,
    output logic [7:0]  alu_operation,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [11:0] alu_pc,
    output logic        alu_run,
    input  logic [15:0] alu_a1,
    input  logic [15:0] alu_b1,
    input  logic [11:0] alu_pcnew,
    input  logic        alu_ion,
    input  logic        irq,
    output logic        irq_ack,
    output logic [15:0] reg_a,
    output logic [15:0] reg_b,
    output logic [11:0] pc,
    output logic [11:0] epc,
    output logic        halted,
    output logic        illegal
);
    state_t      r_state, w_next;
    logic [7:0]  r_op, w_op;
    logic [15:0] r_reg_a, r_reg_b;
    logic [11:0] r_pc, r_epc, w_pc_inc, w_skip_pc;
    logic        r_halted, r_illegal, r_irq_hold, w_irq_take, w_busy;
    dec_t        w_dec;

    // in DECODE the fresh memory word is classified; afterwards the latched opcode is
    assign w_op      = (r_state == S_DECODE) ? imem_data[15:8] : r_op;
    assign w_pc_inc  = r_pc + 12'd1;
    assign w_skip_pc = w_pc_inc + 12'd1;
    assign w_busy    = r_state inside {S_EXEC, S_WAIT, S_WB};

    alu_seq_decode u_decode (.i_op(w_op), .o_dec(w_dec));

    assign imem_en       = (r_state == S_FETCH) && !w_irq_take;
    assign imem_addr     = imem_en ? r_pc : '0;
    assign alu_run       = (r_state == S_EXEC);
    assign irq_ack       = w_irq_take;
    assign alu_operation = w_busy ? r_op : '0;
    assign alu_a         = w_busy ? r_reg_a : '0;
    assign alu_b         = w_busy ? r_reg_b : '0;
    assign alu_pc        = w_busy ? w_pc_inc : '0;
    assign reg_a         = r_reg_a;
    assign reg_b         = r_reg_b;
    assign pc            = r_pc;
    assign epc           = r_epc;
    assign halted        = r_halted;
    assign illegal       = r_illegal;

    // state register
    always_ff @(posedge pixel_clock or negedge reset_n)
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;

    // next state; an interrupt is never taken twice back-to-back so the vectored fetch always happens
    always_comb begin
        w_next     = r_state;
        w_irq_take = 1'b0;
        case (r_state)
            S_IDLE, S_HALT: w_next = start ? S_FETCH : r_state;
            S_FETCH: begin
                w_irq_take = alu_ion && irq && !r_irq_hold;
                w_next     = w_irq_take ? S_FETCH : S_DECODE;
            end
            S_DECODE: w_next = w_dec.is_alu ? S_EXEC :
                               (!w_dec.is_legal || w_op == OP_HLT) ? S_HALT : S_FETCH;
            S_EXEC:   w_next = S_WAIT;
            S_WAIT:   w_next = S_WB;
            S_WB:     w_next = S_FETCH;
            default:  w_next = S_IDLE;
        endcase
    end

    // architectural registers: local ops commit in DECODE, ALU ops commit in WB
    always_ff @(posedge pixel_clock or negedge reset_n)
        if (!reset_n) begin
            r_op       <= '0;
            r_reg_a    <= '0;
            r_reg_b    <= '0;
            r_pc       <= RESET_PC;
            r_epc      <= '0;
            r_halted   <= 1'b0;
            r_illegal  <= 1'b0;
            r_irq_hold <= 1'b0;
        end else begin
            case (r_state)
                S_HALT: if (start) begin
                    r_halted  <= 1'b0;
                    r_illegal <= 1'b0;
                end
                S_FETCH: begin
                    r_irq_hold <= w_irq_take;
                    if (w_irq_take) begin
                        r_epc <= r_pc;
                        r_pc  <= IRQ_VECTOR;
                    end
                end
                S_DECODE: begin
                    r_op <= w_op;
                    if (!w_dec.is_legal) begin
                        r_illegal <= 1'b1;
                        r_halted  <= 1'b1;
                    end else if (!w_dec.is_alu) begin
                        r_pc <= w_pc_inc;
                        if (w_op == OP_LDA) r_reg_a <= {8'h00, imem_data[7:0]};
                        if (w_op == OP_LDB) r_reg_b <= {8'h00, imem_data[7:0]};
                        if (w_op == OP_HLT) r_halted <= 1'b1;
                    end
                end
                S_WB: begin
                    if (w_dec.wr_a) r_reg_a <= alu_a1;
                    else if (w_dec.clr_a) r_reg_a <= '0;
                    if (w_dec.wr_b) r_reg_b <= alu_b1;
                    else if (w_dec.clr_b) r_reg_b <= '0;
                    r_pc <= !w_dec.is_skip ? alu_pcnew :
                            (alu_pcnew == w_skip_pc) ? w_skip_pc : w_pc_inc;
                end
                default: ;
            endcase
        end
endmodule
